// File: rtl/dmem_pkg.sv
//------------------------------------------------------------------------------
// Module   : dmem_pkg
// Purpose  : Shared definitions for the data-memory responder: RV32I
//            load/store funct3 codes, FSM state encoding and the TOHOST
//            mailbox address.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Host mailbox address (only decoded when DMEM_TOHOST_EN is defined)
    localparam logic [31:0] TOHOST_ADDR = 32'hFFFF_FFF0;

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
//------------------------------------------------------------------------------
// Module   : dmem_lane_align
// Purpose  : Combinational byte/halfword lane logic. Extracts and extends the
//            load value, merges store data into the old word, and flags
//            misaligned accesses and illegal funct3 codes.
// Ports    : we        - 1 = store, 0 = load
//            addr_lo   - byte offset within the word
//            funct3    - RV32I load/store funct3
//            old_word  - current contents of the addressed word
//            wdata     - right-aligned store data
//            load_data - extended load result (0 on store or error)
//            store_word- merged word to write back (old_word on error)
//            err       - misaligned or illegal funct3
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        err
);

    logic [4:0]  w_byte_sh;
    logic [4:0]  w_half_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_byte_shifted;

    assign w_byte_sh      = {addr_lo, 3'b000};
    assign w_half_sh      = {addr_lo[1], 4'b0000};
    assign w_byte_shifted = old_word >> w_byte_sh;
    assign w_byte         = w_byte_shifted[7:0];
    assign w_half         = addr_lo[1] ? old_word[31:16] : old_word[15:0];

    always_comb begin
        load_data  = 32'h0;
        store_word = old_word;
        err        = 1'b0;
        case (funct3)
            F3_B: begin
                if (we) begin
                    store_word = (old_word & ~(32'h0000_00FF << w_byte_sh))
                               | ({24'h0, wdata[7:0]} << w_byte_sh);
                end else begin
                    load_data = {{24{w_byte[7]}}, w_byte};
                end
            end
            F3_H: begin
                if (addr_lo[0]) begin
                    err = 1'b1;
                end else if (we) begin
                    store_word = (old_word & ~(32'h0000_FFFF << w_half_sh))
                               | ({16'h0, wdata[15:0]} << w_half_sh);
                end else begin
                    load_data = {{16{w_half[15]}}, w_half};
                end
            end
            F3_W: begin
                if (addr_lo != 2'b00) begin
                    err = 1'b1;
                end else if (we) begin
                    store_word = wdata;
                end else begin
                    load_data = old_word;
                end
            end
            F3_BU: begin
                // Unsigned variants exist only for loads
                if (we) begin
                    err = 1'b1;
                end else begin
                    load_data = {24'h0, w_byte};
                end
            end
            F3_HU: begin
                if (we || addr_lo[0]) begin
                    err = 1'b1;
                end else begin
                    load_data = {16'h0, w_half};
                end
            end
            default: err = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
//------------------------------------------------------------------------------
// Module   : dmem_responder
// Purpose  : Data-memory responder with valid/ready request and response
//            channels and a programmable wait latency. Stores do a lane
//            read-modify-write; loads extract and extend the addressed lane.
// Ports    : clk, rst (async, active low)
//            req_valid/req_ready/req_we/req_addr/req_wdata/req_funct3
//            rsp_valid/rsp_ready/rsp_rdata/rsp_err
//            tohost_data/tohost_valid (only with DMEM_TOHOST_EN)
// Config   : DMEM_TOHOST_EN - decodes TOHOST_ADDR as a host mailbox register
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_TOHOST_EN
    ,
    output logic [31:0] tohost_data,
    output logic        tohost_valid
`endif
);

    localparam int         AW         = $clog2(DEPTH_WORDS);
    localparam bit         C_ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0] C_LAT_M1   = C_ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [2:0]    r_funct3;

    logic          w_accept;
    logic          w_do_access;
    logic          w_acc_we;
    logic [31:0]   w_acc_addr;
    logic [31:0]   w_acc_wdata;
    logic [2:0]    w_acc_funct3;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_old_word;
    logic [31:0]   w_load_data;
    logic [31:0]   w_store_word;
    logic          w_lane_err;
    logic          w_err;
    logic          w_is_tohost;
    logic          w_mem_we;

    logic [31:0]   r_mem [DEPTH_WORDS];

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign w_accept  = req_valid && (r_state == ST_IDLE);

    // With zero latency the access happens on the accepting edge, so the
    // request comes straight from the ports; otherwise from the latched copy.
    assign w_acc_we     = (r_state == ST_IDLE) ? req_we     : r_we;
    assign w_acc_addr   = (r_state == ST_IDLE) ? req_addr   : r_addr;
    assign w_acc_wdata  = (r_state == ST_IDLE) ? req_wdata  : r_wdata;
    assign w_acc_funct3 = (r_state == ST_IDLE) ? req_funct3 : r_funct3;

    // Gated by rst so nothing commits to the (unreset) array while reset is held.
    assign w_do_access = rst && ((C_ZERO_LAT && w_accept) ||
                                 ((r_state == ST_WAIT) && (r_cnt == 4'd0)));

    // Upper address bits are ignored: out-of-range addresses wrap.
    assign w_idx = w_acc_addr[AW+1:2];

`ifdef DMEM_TOHOST_EN
    logic [31:0] r_tohost_data;
    logic        r_tohost_valid;

    assign w_is_tohost = (w_acc_addr == TOHOST_ADDR);
    assign w_old_word  = w_is_tohost ? r_tohost_data : r_mem[w_idx];
    // Only full-word stores may update the mailbox
    assign w_err       = w_lane_err | (w_is_tohost & w_acc_we & (w_acc_funct3 != F3_W));
    assign tohost_data  = r_tohost_data;
    assign tohost_valid = r_tohost_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tohost_data  <= 32'h0;
            r_tohost_valid <= 1'b0;
        end else begin
            r_tohost_valid <= 1'b0;
            if (w_do_access && w_is_tohost && w_acc_we && !w_err) begin
                r_tohost_data  <= w_store_word;
                r_tohost_valid <= 1'b1;
            end
        end
    end
`else
    logic w_unused_addr_hi;

    assign w_is_tohost      = 1'b0;
    assign w_old_word       = r_mem[w_idx];
    assign w_err            = w_lane_err;
    assign w_unused_addr_hi = ^w_acc_addr[31:AW+2];
`endif

    dmem_lane_align u_lane_align (
        .we         (w_acc_we),
        .addr_lo    (w_acc_addr[1:0]),
        .funct3     (w_acc_funct3),
        .old_word   (w_old_word),
        .wdata      (w_acc_wdata),
        .load_data  (w_load_data),
        .store_word (w_store_word),
        .err        (w_lane_err)
    );

    assign w_mem_we = w_do_access && w_acc_we && !w_err && !w_is_tohost;

    // Array contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_store_word;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next_state = C_ZERO_LAT ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request latch, wait counter and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_funct3  <= 3'b000;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_funct3 <= req_funct3;
                r_cnt    <= C_LAT_M1;
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_do_access) begin
                rsp_rdata <= (w_err || w_acc_we) ? 32'h0 : w_load_data;
                rsp_err   <= w_err;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder (LATENCY=2). Table of
//            load/store vectors with expected results queued at issue and
//            compared on response, plus backpressure, reset-abort and
//            optional TOHOST (DMEM_TOHOST_EN) sequences.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT = 2;
    localparam int NV  = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_funct3 = 3'b000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_TOHOST_EN
    logic [31:0] tohost_data;
    logic        tohost_valid;
`endif

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
`ifdef DMEM_TOHOST_EN
        ,
        .tohost_data  (tohost_data),
        .tohost_valid (tohost_valid)
`endif
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[NV];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, input logic [31:0] er, input logic ee);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic drive_req(input vec_t v);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_funct3 = v.f3;
    endtask

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic issue(input vec_t v, input bit expect_rsp);
        exp_t e;
        int   n = 0;
        drive_req(v);
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) check("accept_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (expect_rsp) begin
            e.rdata = v.exp_rdata;
            e.err   = v.exp_err;
            sb_q.push_back(e);
        end
    endtask

    // Waits for rsp_valid; the first response cycle follows LAT further edges.
    task automatic wait_rsp(input string name, output exp_t e);
        int lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check({name, "_lat"}, 32'(lat), 32'(LAT));
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
            e.rdata = 32'hx; e.err = 1'bx;
        end else begin
            e = sb_q.pop_front();
        end
    endtask

    task automatic collect(input string name, input int backp);
        exp_t e;
        wait_rsp(name, e);
        for (int i = 0; i < backp; i++) begin
            check({name, "_bp_valid"}, 32'(rsp_valid), 32'd1);
            check({name, "_bp_rdata"}, rsp_rdata, e.rdata);
            check({name, "_bp_ready"}, 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        check({name, "_rdata"}, rsp_rdata, e.rdata);
        check({name, "_err"}, 32'(rsp_err), 32'(e.err));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({name, "_done"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic run(input string name, input vec_t v, input int backp);
        issue(v, 1'b1);
        collect(name, backp);
    endtask

    initial begin
        exp_t e;
        int   seen;

        tbl[0]  = mk(1'b1, 32'h10,   32'hDEADBEEF, F3_W,   32'h0,        1'b0);
        tbl[1]  = mk(1'b0, 32'h10,   32'h0,        F3_W,   32'hDEADBEEF, 1'b0);
        tbl[2]  = mk(1'b1, 32'h10,   32'h11223344, F3_W,   32'h0,        1'b0);
        tbl[3]  = mk(1'b1, 32'h13,   32'h80,       F3_B,   32'h0,        1'b0);
        tbl[4]  = mk(1'b0, 32'h13,   32'h0,        F3_B,   32'hFFFFFF80, 1'b0);
        tbl[5]  = mk(1'b0, 32'h13,   32'h0,        F3_BU,  32'h00000080, 1'b0);
        tbl[6]  = mk(1'b0, 32'h10,   32'h0,        F3_W,   32'h80223344, 1'b0);
        tbl[7]  = mk(1'b1, 32'h00,   32'h0,        F3_W,   32'h0,        1'b0);
        tbl[8]  = mk(1'b1, 32'h02,   32'h1234BEEF, F3_H,   32'h0,        1'b0);
        tbl[9]  = mk(1'b0, 32'h02,   32'h0,        F3_H,   32'hFFFFBEEF, 1'b0);
        tbl[10] = mk(1'b0, 32'h01,   32'h0,        F3_W,   32'h0,        1'b1);
        tbl[11] = mk(1'b1, 32'h03,   32'h1234,     F3_H,   32'h0,        1'b1);
        tbl[12] = mk(1'b0, 32'h00,   32'h0,        F3_W,   32'hBEEF0000, 1'b0);
        tbl[13] = mk(1'b0, 32'h02,   32'h0,        F3_HU,  32'h0000BEEF, 1'b0);
        tbl[14] = mk(1'b0, 32'h00,   32'h0,        3'b011, 32'h0,        1'b1);
        tbl[15] = mk(1'b1, 32'h00,   32'hFFFFFFFF, F3_BU,  32'h0,        1'b1);
        tbl[16] = mk(1'b0, 32'h1012, 32'h0,        F3_HU,  32'h00008022, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err",   32'(rsp_err), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            run($sformatf("vec%0d", i), tbl[i], (i == 1) ? 3 : 0);
        end

        // Backpressure with a new request offered while the response is held
        issue(mk(1'b0, 32'h10, 32'h0, F3_W, 32'h80223344, 1'b0), 1'b1);
        wait_rsp("bp", e);
        drive_req(mk(1'b0, 32'h13, 32'h0, F3_BU, 32'h80, 1'b0));
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, e.rdata);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("bp_err", 32'(rsp_err), 32'(e.err));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_idle_valid", 32'(rsp_valid), 32'd0);
        check("bp_idle_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_next_taken", 32'(req_ready), 32'd0);
        e.rdata = 32'h00000080; e.err = 1'b0;
        sb_q.push_back(e);
        collect("bp_next", 0);

        // Reset during WAIT aborts the store
        run("pre_store", mk(1'b1, 32'h20, 32'h77, F3_W, 32'h0, 1'b0), 0);
        issue(mk(1'b1, 32'h20, 32'h5, F3_W, 32'h0, 1'b0), 1'b0);
        #1 rst = 1'b0;
        #2 rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);
        run("abort_load", mk(1'b0, 32'h20, 32'h0, F3_W, 32'h77, 1'b0), 0);

`ifdef DMEM_TOHOST_EN
        issue(mk(1'b1, TOHOST_ADDR, 32'h1, F3_W, 32'h0, 1'b0), 1'b1);
        wait_rsp("tohost_sw", e);
        check("tohost_valid_hi", 32'(tohost_valid), 32'd1);
        check("tohost_data", tohost_data, 32'h1);
        check("tohost_sw_err", 32'(rsp_err), 32'(e.err));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("tohost_valid_lo", 32'(tohost_valid), 32'd0);
        run("tohost_lw", mk(1'b0, TOHOST_ADDR, 32'h0, F3_W, 32'h1, 1'b0), 0);
        run("tohost_sb", mk(1'b1, TOHOST_ADDR, 32'h2, F3_B, 32'h0, 1'b1), 0);
`else
        // Without the mailbox, 0xFFFFFFF0 wraps onto word 0x3FC (byte 0xFF0)
        run("alias_sw", mk(1'b1, 32'hFF0, 32'hA5A5, F3_W, 32'h0, 1'b0), 0);
        run("alias_lw", mk(1'b0, TOHOST_ADDR, 32'h0, F3_W, 32'hA5A5, 1'b0), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
